// File: rtl/stopwatch_pkg.sv
// Shared time types and carry/borrow helpers for the stopwatch.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stopwatch_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  // Hours field width of the shared time struct; the top's HR_W must match it.
  localparam int TIME_HR_W = 5;

  typedef struct packed {
    logic [TIME_HR_W-1:0] hr;
    logic [5:0]           min;
    logic [5:0]           sec;
  } time_t;

  // One-second increment with sec->min->hr carry; hours wrap at max_hours.
  function automatic time_t time_inc(time_t t, int unsigned max_hours);
    time_t r;
    r = t;
    if (t.sec != 6'(SEC_MAX)) begin
      r.sec = t.sec + 6'd1;
    end else begin
      r.sec = '0;
      if (t.min != 6'(MIN_MAX)) begin
        r.min = t.min + 6'd1;
      end else begin
        r.min = '0;
        if (t.hr == TIME_HR_W'(max_hours - 1)) r.hr = '0;
        else                                   r.hr = t.hr + TIME_HR_W'(1);
      end
    end
    return r;
  endfunction

  // One-second decrement with borrow; callers never pass 0:00:00.
  function automatic time_t time_dec(time_t t, int unsigned max_hours);
    time_t r;
    r = t;
    if (t.sec != 6'd0) begin
      r.sec = t.sec - 6'd1;
    end else begin
      r.sec = 6'(SEC_MAX);
      if (t.min != 6'd0) begin
        r.min = t.min - 6'd1;
      end else begin
        r.min = 6'(MIN_MAX);
        if (t.hr != '0) r.hr = t.hr - TIME_HR_W'(1);
        else            r.hr = TIME_HR_W'(max_hours - 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Show-ahead FIFO for lap entries with sticky drop-on-full flag.
// Latency: pushed entry visible on dout the cycle after push when empty; head advances the cycle after pop.
// Backpressure: none; a push while full without a simultaneous pop is dropped and flagged.
module lap_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pop_ok, push_ok;

  // Next-state: pointers, occupancy, registered head and sticky overflow.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    head_d  = head_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full push still lands.
    push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      head_d  = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop_ok) rd_d = rd_q + PTR_W'(1);
      if (push && !push_ok) ovf_d = 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      valid_d = (count_d != '0);
      // Head holds its last value once the buffer drains.
      if (count_d != '0) begin
        if (count_q == CNT_W'(pop_ok)) head_d = din;
        else                           head_d = mem_q[rd_d];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout     = head_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = ~valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/stopwatch_lap.sv
// H:M:S stopwatch with up/down count, preset load and lap capture buffer.
// Latency: commands act at the next edge; first tick TICK_DIV cycles after run rises.
// Backpressure: none; laps into a full buffer are dropped and flagged sticky.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 10,
  parameter int HR_W      = TIME_HR_W,
  parameter int MAX_HOURS = 24,
  parameter int LAP_DEPTH = 4,
  localparam int DIV_W    = $clog2(TICK_DIV),
  localparam int CNT_W    = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode_down,
  input  logic             load,
  input  logic [5:0]       load_sec,
  input  logic [5:0]       load_min,
  input  logic [HR_W-1:0]  load_hr,
  input  logic             lap,
  input  logic             lap_rd,
  output logic [5:0]       seconds,
  output logic [5:0]       minutes,
  output logic [HR_W-1:0]  hours,
  output logic             run,
  output logic             expired,
  output logic             lap_valid,
  output logic [5:0]       lap_sec,
  output logic [5:0]       lap_min,
  output logic [HR_W-1:0]  lap_hr,
  output logic [CNT_W-1:0] lap_count,
  output logic             lap_overflow
);

  time_t            time_q, time_d, load_t, lap_head;
  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             expired_q, expired_d;
  logic             tick, time_zero, lap_empty, lap_full;

  // Saturate the preset fields into a legal time.
  always_comb begin
    load_t     = '0;
    load_t.sec = (load_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : load_sec;
    load_t.min = (load_min > 6'(MIN_MAX)) ? 6'(MIN_MAX) : load_min;
    load_t.hr  = (32'(load_hr) >= MAX_HOURS) ? TIME_HR_W'(MAX_HOURS - 1)
                                             : TIME_HR_W'(load_hr);
  end

  // Command priority clear > load > stop > start, then tick-driven counting.
  always_comb begin
    time_d    = time_q;
    div_d     = div_q;
    run_d     = run_q;
    expired_d = expired_q;
    tick      = run_q && (div_q == DIV_W'(TICK_DIV - 1));
    time_zero = (time_q == '0);
    if (clear) begin
      time_d    = '0;
      div_d     = '0;
      run_d     = 1'b0;
      expired_d = 1'b0;
    end else if (load && !run_q) begin
      time_d    = load_t;
      div_d     = '0;
      expired_d = 1'b0;
    end else begin
      if (run_q) div_d = tick ? '0 : div_q + DIV_W'(1);
      if (stop)                                   run_d = 1'b0;
      else if (start && !(mode_down && time_zero)) run_d = 1'b1;
      if (tick) begin
        if (mode_down) begin
          // Countdown stops at zero; the tick reaching zero also halts the run.
          if (!time_zero) begin
            time_d = time_dec(time_q, MAX_HOURS);
            if (time_d == '0) begin
              expired_d = 1'b1;
              run_d     = 1'b0;
            end
          end
        end else begin
          time_d = time_inc(time_q, MAX_HOURS);
        end
      end
    end
  end

  // Time base registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_q    <= '0;
      div_q     <= '0;
      run_q     <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      time_q    <= time_d;
      div_q     <= div_d;
      run_q     <= run_d;
      expired_q <= expired_d;
    end
  end

  // Laps capture the time currently on the outputs; clear flushes and wins.
  lap_fifo #(
    .WIDTH ($bits(time_t)),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (lap),
    .pop      (lap_rd),
    .flush    (clear),
    .din      (time_q),
    .dout     (lap_head),
    .full     (lap_full),
    .empty    (lap_empty),
    .count    (lap_count),
    .overflow (lap_overflow)
  );

  assign seconds   = time_q.sec;
  assign minutes   = time_q.min;
  assign hours     = HR_W'(time_q.hr);
  assign run       = run_q;
  assign expired   = expired_q;
  // A full buffer is never empty, so the head is valid whenever full is set.
  assign lap_valid = ~lap_empty | lap_full;
  assign lap_sec   = lap_head.sec;
  assign lap_min   = lap_head.min;
  assign lap_hr    = HR_W'(lap_head.hr);

endmodule
